reg_file_multiport: RTL



---
 rtl/reg_file_multiport.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_file_multiport.sv
// Multiport register file: one synchronous write port, READ_PORTS registered read ports,
// sequenced hardware clear. Define REG_FILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_multiport #(
    parameter int WORD_SIZE  = 16,
    parameter int NIB_SIZE   = 4,
    parameter int REG_COUNT  = 16,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [READ_PORTS-1:0]           rd_en,
    input  logic [READ_PORTS*NIB_SIZE-1:0]  rd_addr,
    output logic [READ_PORTS*WORD_SIZE-1:0] rd_data,
    input  logic                            wr_en,
    input  logic [NIB_SIZE-1:0]             wr_addr,
    input  logic [WORD_SIZE-1:0]            wr_data,
    input  logic                            clear,
    output logic                            ready
);

    localparam int                IDX_W    = $clog2(REG_COUNT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REG_COUNT - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t                 state, next_state;
    logic [IDX_W-1:0]       idx, next_idx;
    logic [WORD_SIZE-1:0]   mem [REG_COUNT];
    logic [WORD_SIZE-1:0]   rd_val [READ_PORTS];
    logic                   wr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            CLEAR: begin
                next_idx = idx + IDX_W'(1);
                if (idx == LAST_IDX) next_state = IDLE;
            end
            IDLE: begin
                if (clear) begin
                    next_state = CLEAR;
                    next_idx   = '0;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    assign ready = (state == IDLE);

    // Clear wins over a same-cycle write; out-of-range and hardwired-zero writes vanish.
    assign wr_ok = (state == IDLE) && wr_en && !clear
                && (32'(wr_addr) < 32'(REG_COUNT))
                && !((ZERO_REG != 0) && (wr_addr == '0));

    // NOTE: the storage array has no reset branch on purpose; the clear sweep
    // defines its contents, which keeps it mappable onto plain flops/LUT-RAM.
    always_ff @(posedge clk) begin
        for (int r = 0; r < REG_COUNT; r++) begin
            if (state == CLEAR && idx == IDX_W'(r))
                mem[r] <= '0;
            else if (wr_ok && wr_addr == NIB_SIZE'(r))
                mem[r] <= wr_data;
        end
    end

    // Address decode per port; no match (out of range or zero reg) leaves the value at 0.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_val[p] = '0;
            for (int r = 0; r < REG_COUNT; r++) begin
                if (rd_addr[p*NIB_SIZE +: NIB_SIZE] == NIB_SIZE'(r)
                    && !((ZERO_REG != 0) && (r == 0)))
                    rd_val[p] = mem[r];
            end
`ifdef REG_FILE_BYPASS_EN
            if (wr_ok && wr_addr == rd_addr[p*NIB_SIZE +: NIB_SIZE])
                rd_val[p] = wr_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state == CLEAR) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < READ_PORTS; p++) begin
                if (rd_en[p]) rd_data[p*WORD_SIZE +: WORD_SIZE] <= rd_val[p];
            end
        end
    end

endmodule
